dma_job_scheduler: RTL and testbench

Queues DMA transfer descriptors (src, dst, len) from a requester.
Programs the DMA CSR block one job at a time over a simple register-write channel: SRC, DST, LEN, then CFG=0x3 to start.
Waits for dma_done/dma_error or a watchdog timeout, reports per-job status, then launches the next queued job.
Sits between the CPU/host side and the DMA CSR port, replacing manual CPU sequencing of the four CSR writes.

---
 rtl/dma_pkg.sv | 41 ++++
 rtl/dma_desc_fifo.sv | 56 +++++
 rtl/dma_job_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_dma_job_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA job scheduler: CSR map, start encoding,
// scheduler states and the transfer descriptor payload.
package dma_pkg;

  localparam int unsigned CSR_ADDR_W  = 12;
  localparam int unsigned CSR_DATA_W  = 32;
  localparam int unsigned DESC_ADDR_W = 32;
  localparam int unsigned DESC_LEN_W  = 32;

  // DMA CSR block register offsets
  localparam logic [CSR_ADDR_W-1:0] CSR_SRC = 12'h000;
  localparam logic [CSR_ADDR_W-1:0] CSR_DST = 12'h004;
  localparam logic [CSR_ADDR_W-1:0] CSR_LEN = 12'h008;
  localparam logic [CSR_ADDR_W-1:0] CSR_CFG = 12'h00C;

  localparam logic [CSR_DATA_W-1:0] CFG_START_DEFAULT = 32'h0000_0003;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WR_SRC = 4'd1,
    ST_WR_DST = 4'd2,
    ST_WR_LEN = 4'd3,
    ST_WR_CFG = 4'd4,
    ST_WAIT   = 4'd5,
    ST_DONE   = 4'd6,
    ST_ERR    = 4'd7,
    ST_HALT   = 4'd8
  } sched_state_e;

  typedef struct packed {
    logic [DESC_ADDR_W-1:0] src;
    logic [DESC_ADDR_W-1:0] dst;
    logic [DESC_LEN_W-1:0]  len;
  } dma_desc_t;

  // A job is owned by the scheduler everywhere except IDLE and HALT.
  function automatic logic state_is_busy(input sched_state_e s);
    return !((s == ST_IDLE) || (s == ST_HALT));
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with show-ahead read data and occupancy count.
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  dma_desc_t              wdata,
  input  logic                   pop,
  output dma_desc_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  dma_desc_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dma_job_scheduler.sv
// Queues DMA descriptors and programs the DMA CSR block one job at a time,
// then waits for done/error/watchdog and reports per-job status.
module dma_job_scheduler
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 32,
  parameter int unsigned TIMEOUT   = 5000,
  parameter logic [31:0] CFG_START = CFG_START_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [ADDR_W-1:0]      job_src_i,
  input  logic [ADDR_W-1:0]      job_dst_i,
  input  logic [LEN_W-1:0]       job_len_i,
  output logic                   csr_wr_valid_o,
  input  logic                   csr_wr_ready_i,
  output logic [11:0]            csr_wr_addr_o,
  output logic [31:0]            csr_wr_data_o,
  input  logic                   dma_done_i,
  input  logic                   dma_error_i,
  input  logic                   err_clear_i,
  output logic                   busy_o,
  output logic                   job_done_o,
  output logic                   job_err_o,
  output logic                   timeout_o,
  output logic [$clog2(DEPTH):0] pending_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  sched_state_e            state_q, state_d;
  dma_desc_t               desc_q, desc_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic                    timeout_d;
  logic                    csr_valid_d;
  logic [CSR_ADDR_W-1:0]   csr_addr_d;
  logic [CSR_DATA_W-1:0]   csr_data_d;
  logic                    busy_d;
  logic                    job_done_d;
  logic                    job_err_d;

  dma_desc_t               fifo_wdata;
  dma_desc_t               fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;

  assign fifo_wdata.src = DESC_ADDR_W'(job_src_i);
  assign fifo_wdata.dst = DESC_ADDR_W'(job_dst_i);
  assign fifo_wdata.len = DESC_LEN_W'(job_len_i);
  assign job_ready_o    = !fifo_full;

  dma_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid_i),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_o)
  );

  // State, working descriptor, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      desc_q         <= '0;
      wdog_q         <= '0;
      timeout_o      <= 1'b0;
      csr_wr_valid_o <= 1'b0;
      csr_wr_addr_o  <= '0;
      csr_wr_data_o  <= '0;
      busy_o         <= 1'b0;
      job_done_o     <= 1'b0;
      job_err_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      desc_q         <= desc_d;
      wdog_q         <= wdog_d;
      timeout_o      <= timeout_d;
      csr_wr_valid_o <= csr_valid_d;
      csr_wr_addr_o  <= csr_addr_d;
      csr_wr_data_o  <= csr_data_d;
      busy_o         <= busy_d;
      job_done_o     <= job_done_d;
      job_err_o      <= job_err_d;
    end
  end

  // Next state; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d     = state_q;
    desc_d      = desc_q;
    wdog_d      = wdog_q;
    timeout_d   = timeout_o;
    fifo_pop    = 1'b0;
    csr_valid_d = 1'b0;
    csr_addr_d  = csr_wr_addr_o;
    csr_data_d  = csr_wr_data_o;
    job_done_d  = 1'b0;
    job_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          desc_d   = fifo_rdata;
          state_d  = (fifo_rdata.len == '0) ? ST_DONE : ST_WR_SRC;
        end
      end
      ST_WR_SRC: if (csr_wr_ready_i) state_d = ST_WR_DST;
      ST_WR_DST: if (csr_wr_ready_i) state_d = ST_WR_LEN;
      ST_WR_LEN: if (csr_wr_ready_i) state_d = ST_WR_CFG;
      ST_WR_CFG: begin
        if (csr_wr_ready_i) begin
          wdog_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Error has priority over done; watchdog saturates instead of wrapping.
        if (dma_error_i) begin
          state_d = ST_ERR;
        end else if (dma_done_i) begin
          state_d = ST_DONE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else if (wdog_q < WD_W'(TIMEOUT)) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_HALT;
      ST_HALT: begin
        if (err_clear_i) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_WR_SRC: begin
        csr_valid_d = 1'b1;
        csr_addr_d  = CSR_SRC;
        csr_data_d  = CSR_DATA_W'(desc_d.src);
      end
      ST_WR_DST: begin
        csr_valid_d = 1'b1;
        csr_addr_d  = CSR_DST;
        csr_data_d  = CSR_DATA_W'(desc_d.dst);
      end
      ST_WR_LEN: begin
        csr_valid_d = 1'b1;
        csr_addr_d  = CSR_LEN;
        csr_data_d  = CSR_DATA_W'(desc_d.len);
      end
      ST_WR_CFG: begin
        csr_valid_d = 1'b1;
        csr_addr_d  = CSR_CFG;
        csr_data_d  = CFG_START;
      end
      ST_DONE: job_done_d = 1'b1;
      ST_ERR:  job_err_d  = 1'b1;
      default: ;
    endcase

    busy_d = state_is_busy(state_d);
  end

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed self-checking bench for dma_job_scheduler (DEPTH=4, TIMEOUT=20).
module tb_dma_job_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [31:0] job_src_i = '0;
  logic [31:0] job_dst_i = '0;
  logic [31:0] job_len_i = '0;
  logic        csr_wr_valid_o;
  logic        csr_wr_ready_i = 1'b1;
  logic [11:0] csr_wr_addr_o;
  logic [31:0] csr_wr_data_o;
  logic        dma_done_i = 1'b0;
  logic        dma_error_i = 1'b0;
  logic        err_clear_i = 1'b0;
  logic        busy_o;
  logic        job_done_o;
  logic        job_err_o;
  logic        timeout_o;
  logic [2:0]  pending_o;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [43:0] wlog[$];

  dma_job_scheduler #(
    .DEPTH   (4),
    .ADDR_W  (32),
    .LEN_W   (32),
    .TIMEOUT (20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_src_i      (job_src_i),
    .job_dst_i      (job_dst_i),
    .job_len_i      (job_len_i),
    .csr_wr_valid_o (csr_wr_valid_o),
    .csr_wr_ready_i (csr_wr_ready_i),
    .csr_wr_addr_o  (csr_wr_addr_o),
    .csr_wr_data_o  (csr_wr_data_o),
    .dma_done_i     (dma_done_i),
    .dma_error_i    (dma_error_i),
    .err_clear_i    (err_clear_i),
    .busy_o         (busy_o),
    .job_done_o     (job_done_o),
    .job_err_o      (job_err_o),
    .timeout_o      (timeout_o),
    .pending_o      (pending_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge sees what the next posedge samples.
  always @(negedge clk) begin
    if (csr_wr_valid_o && csr_wr_ready_i) wlog.push_back({csr_wr_addr_o, csr_wr_data_o});
    if (job_done_o) done_cnt++;
    if (job_err_o)  err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    job_valid_i = 1'b1;
    job_src_i   = s;
    job_dst_i   = d;
    job_len_i   = l;
  endtask

  task automatic wait_writes(input string tag, input int target);
    for (int n = 0; n < 200 && wlog.size() < target; n++) tick();
    chk(tag, 64'(wlog.size() >= target), 64'd1);
  endtask

  task automatic pulse_done(input string tag);
    dma_done_i = 1'b1;
    tick();
    chk(tag, 64'(job_done_o), 64'd1);
    dma_done_i = 1'b0;
    tick();
  endtask

  task automatic chk_job(input string tag, input int base,
                         input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    chk({tag, "_src"}, 64'(wlog[base]),     64'({12'h000, s}));
    chk({tag, "_dst"}, 64'(wlog[base + 1]), 64'({12'h004, d}));
    chk({tag, "_len"}, 64'(wlog[base + 2]), 64'({12'h008, l}));
    chk({tag, "_cfg"}, 64'(wlog[base + 3]), 64'({12'h00C, 32'h0000_0003}));
  endtask

  initial begin
    int base;
    int dbase;
    int ebase;
    logic [43:0] exp_w [4];

    // Reset values
    tick(); tick();
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_ready",   64'(job_ready_o), 64'd1);
    chk("rst_valid",   64'(csr_wr_valid_o), 64'd0);
    chk("rst_word",    64'({csr_wr_addr_o, csr_wr_data_o}), 64'd0);
    chk("rst_flags",   64'({busy_o, job_done_o, job_err_o, timeout_o}), 64'd0);
    rst = 1'b0;
    tick();

    // Single job, ready tied high
    base = wlog.size();
    dbase = done_cnt;
    drive_job(32'h8100_0100, 32'h8400_0100, 32'h0000_0040);
    tick();
    job_valid_i = 1'b0;
    chk("s_pend1", 64'(pending_o), 64'd1);
    chk("s_novalid", 64'(csr_wr_valid_o), 64'd0);
    tick();
    chk("s_lat_valid", 64'(csr_wr_valid_o), 64'd1);
    chk("s_lat_word", 64'({csr_wr_addr_o, csr_wr_data_o}), 64'({12'h000, 32'h8100_0100}));
    chk("s_pend0", 64'(pending_o), 64'd0);
    chk("s_busy", 64'(busy_o), 64'd1);
    tick();
    chk("s_dst", 64'({csr_wr_addr_o, csr_wr_data_o}), 64'({12'h004, 32'h8400_0100}));
    tick();
    chk("s_len", 64'({csr_wr_addr_o, csr_wr_data_o}), 64'({12'h008, 32'h0000_0040}));
    tick();
    chk("s_cfg", 64'({csr_wr_addr_o, csr_wr_data_o}), 64'({12'h00C, 32'h0000_0003}));
    tick();
    chk("s_wait_valid", 64'(csr_wr_valid_o), 64'd0);
    chk("s_wait_busy", 64'(busy_o), 64'd1);
    repeat (9) tick();
    dma_done_i = 1'b1;
    tick();
    chk("s_done", 64'(job_done_o), 64'd1);
    dma_done_i = 1'b0;
    tick();
    chk("s_done_off", 64'(job_done_o), 64'd0);
    chk("s_idle_busy", 64'(busy_o), 64'd0);
    chk("s_end_pend", 64'(pending_o), 64'd0);
    chk("s_nwrites", 64'(wlog.size() - base), 64'd4);
    chk_job("s_log", base, 32'h8100_0100, 32'h8400_0100, 32'h0000_0040);
    chk("s_ndone", 64'(done_cnt - dbase), 64'd1);

    // Back-pressure: ready low 7 cycles on each write
    base = wlog.size();
    exp_w[0] = {12'h000, 32'h1000_0000};
    exp_w[1] = {12'h004, 32'h2000_0000};
    exp_w[2] = {12'h008, 32'h0000_0100};
    exp_w[3] = {12'h00C, 32'h0000_0003};
    csr_wr_ready_i = 1'b0;
    drive_job(32'h1000_0000, 32'h2000_0000, 32'h0000_0100);
    tick();
    job_valid_i = 1'b0;
    tick();
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 7; c++) begin
        chk("bp_valid", 64'(csr_wr_valid_o), 64'd1);
        chk("bp_word", 64'({csr_wr_addr_o, csr_wr_data_o}), 64'(exp_w[w]));
        tick();
      end
      csr_wr_ready_i = 1'b1;
      tick();
      csr_wr_ready_i = 1'b0;
    end
    chk("bp_wait_valid", 64'(csr_wr_valid_o), 64'd0);
    chk("bp_nwrites", 64'(wlog.size() - base), 64'd4);
    chk_job("bp_log", base, 32'h1000_0000, 32'h2000_0000, 32'h0000_0100);
    csr_wr_ready_i = 1'b1;
    pulse_done("bp_done");

    // Queue full: five jobs back to back, first one in flight
    base = wlog.size();
    dbase = done_cnt;
    for (int k = 0; k < 5; k++) begin
      drive_job(32'h3000_0000 + 32'(k) * 32'h100, 32'h5000_0000 + 32'(k) * 32'h100,
                32'h10 * 32'(k + 1));
      tick();
    end
    job_valid_i = 1'b0;
    chk("q_full_ready", 64'(job_ready_o), 64'd0);
    chk("q_full_pend", 64'(pending_o), 64'd4);
    for (int k = 0; k < 5; k++) begin
      wait_writes("q_launch", base + 4 * (k + 1));
      pulse_done("q_done");
    end
    chk("q_ndone", 64'(done_cnt - dbase), 64'd5);
    chk("q_pend_end", 64'(pending_o), 64'd0);
    chk("q_ready_end", 64'(job_ready_o), 64'd1);
    for (int k = 0; k < 5; k++)
      chk_job("q_order", base + 4 * k, 32'h3000_0000 + 32'(k) * 32'h100,
              32'h5000_0000 + 32'(k) * 32'h100, 32'h10 * 32'(k + 1));

    // Error wins over done, then HALT holds the queue
    base = wlog.size();
    dbase = done_cnt;
    ebase = err_cnt;
    drive_job(32'h6000_0000, 32'h7000_0000, 32'h0000_0080);
    tick();
    drive_job(32'h6100_0000, 32'h7100_0000, 32'h0000_0090);
    tick();
    job_valid_i = 1'b0;
    wait_writes("e_launch", base + 4);
    dma_error_i = 1'b1;
    dma_done_i  = 1'b1;
    tick();
    chk("e_err", 64'(job_err_o), 64'd1);
    chk("e_nodone", 64'(job_done_o), 64'd0);
    chk("e_no_to", 64'(timeout_o), 64'd0);
    dma_error_i = 1'b0;
    dma_done_i  = 1'b0;
    tick();
    chk("e_halt_busy", 64'(busy_o), 64'd0);
    chk("e_err_off", 64'(job_err_o), 64'd0);
    drive_job(32'h6200_0000, 32'h7200_0000, 32'h0000_00A0);
    tick();
    job_valid_i = 1'b0;
    repeat (4) tick();
    chk("e_halt_pend", 64'(pending_o), 64'd2);
    chk("e_halt_valid", 64'(csr_wr_valid_o), 64'd0);
    chk("e_halt_nolaunch", 64'(wlog.size() - base), 64'd4);
    chk("e_counts", 64'({done_cnt - dbase, err_cnt - ebase}), 64'({32'd0, 32'd1}));
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    tick();
    chk("e_resume", 64'({csr_wr_valid_o, csr_wr_data_o}), 64'({1'b1, 32'h6100_0000}));
    wait_writes("e_b_launch", base + 8);
    pulse_done("e_b_done");
    wait_writes("e_c_launch", base + 12);
    pulse_done("e_c_done");
    chk_job("e_b_log", base + 4, 32'h6100_0000, 32'h7100_0000, 32'h0000_0090);
    chk_job("e_c_log", base + 8, 32'h6200_0000, 32'h7200_0000, 32'h0000_00A0);

    // Watchdog timeout at 20 cycles after WAIT entry
    base = wlog.size();
    drive_job(32'h9000_0000, 32'h9100_0000, 32'h0000_0020);
    tick();
    job_valid_i = 1'b0;
    wait_writes("t_launch", base + 4);
    repeat (19) tick();
    chk("t_pre_err", 64'({job_err_o, timeout_o, busy_o}), 64'b001);
    tick();
    chk("t_err", 64'({job_err_o, timeout_o}), 64'b11);
    tick();
    chk("t_halt", 64'({job_err_o, timeout_o, busy_o}), 64'b010);
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    chk("t_clear", 64'(timeout_o), 64'd0);

    // Zero-length job completes without CSR writes
    base = wlog.size();
    drive_job(32'hA000_0000, 32'hB000_0000, 32'h0000_0000);
    tick();
    job_valid_i = 1'b0;
    tick();
    chk("z_done", 64'({job_done_o, csr_wr_valid_o, busy_o}), 64'b101);
    tick();
    chk("z_idle", 64'({job_done_o, busy_o, pending_o}), 64'd0);
    repeat (3) tick();
    chk("z_nowrites", 64'(wlog.size() - base), 64'd0);

    // Reset while writing DST
    drive_job(32'hC000_0000, 32'hD000_0000, 32'h0000_0030);
    tick();
    drive_job(32'hC100_0000, 32'hD100_0000, 32'h0000_0030);
    tick();
    job_valid_i = 1'b0;
    tick();
    chk("r_in_dst", 64'({csr_wr_valid_o, csr_wr_addr_o, pending_o}), 64'({1'b1, 12'h004, 3'd1}));
    rst = 1'b1;
    tick();
    chk("r_valid", 64'(csr_wr_valid_o), 64'd0);
    chk("r_pend", 64'(pending_o), 64'd0);
    chk("r_outs", 64'({busy_o, job_ready_o, csr_wr_addr_o, csr_wr_data_o}), 64'({1'b0, 1'b1, 44'd0}));
    rst = 1'b0;
    base = wlog.size();
    repeat (6) tick();
    chk("r_nowrites", 64'(wlog.size() - base), 64'd0);
    chk("r_idle", 64'({csr_wr_valid_o, busy_o}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
